// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 3-stage NOR-augmented LFSR sequence and its
// receive-side checker:
//   - chk_state_t   : checker FSM state (HUNT=0, SYNC=1, LOCKED=2)
//   - LFSR_LEN      : number of history stages (3)
//   - lfsr_next_bit : feedback function; hist[0] is the newest bit,
//                     hist[2] the oldest.
// The NOR term makes the all-zero history produce a 1, so the sequence is a
// full period-8 cycle with no lockup state.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_LEN = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic lfsr_next_bit(input logic [LFSR_LEN-1:0] hist);
        return hist[0] ^ hist[2] ^ ~(hist[0] | hist[1]);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Registered saturating up-counter with enable. Counts up by one on each
// enabled cycle and sticks at all-ones. Cleared only by reset.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset (count -> 0)
//   en     in   increment request
//   count  out  current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        count_nxt_s = count_r;
        if (en && (count_r != {W{1'b1}})) begin
            count_nxt_s = count_r + W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the period-8 NOR-augmented LFSR sequence.
// HUNT fills a 3-bit history from the received stream, SYNC checks that
// predictions keep matching (reseeding from received bits), LOCKED runs a
// flywheel (history fed from predictions) and reports mismatches.
//
// Optional build macro: LFSR_CHK_BITCNT_EN adds bit_count, the saturating
// number of valid bits compared while LOCKED (for bit-error-rate figures).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   valid_in   in   data_in carries a new sequence bit this cycle
//   data_in    in   received sequence bit
//   locked     out  checker is LOCKED (registered)
//   err_pulse  out  one-cycle pulse after a mismatch while LOCKED
//   err_count  out  saturating count of LOCKED mismatches
//   state_out  out  FSM state (HUNT=0, SYNC=1, LOCKED=2)
//   bit_count  out  [LFSR_CHK_BITCNT_EN only] LOCKED bits compared
// -----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT  = 8,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 data_in,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef LFSR_CHK_BITCNT_EN
    output logic [31:0]          bit_count,
`endif
    output logic [1:0]           state_out
);

    localparam logic [7:0] LOCK_CNT_V  = 8'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_V    = 4'(UNLOCK_ERRS);

    chk_state_t          state_r;
    chk_state_t          state_nxt_s;
    logic [LFSR_LEN-1:0] hist_r;
    logic [LFSR_LEN-1:0] hist_nxt_s;
    logic [1:0]          fill_r;
    logic [1:0]          fill_nxt_s;
    logic [7:0]          match_r;
    logic [7:0]          match_nxt_s;
    logic [3:0]          cerr_r;
    logic [3:0]          cerr_nxt_s;

    logic                pred_s;
    logic                miss_s;
    logic                lock_err_s;

    logic                locked_r;
    logic                err_pulse_r;
    logic [1:0]          state_out_r;

    assign pred_s     = lfsr_next_bit(hist_r);
    assign miss_s     = (data_in != pred_s);
    assign lock_err_s = valid_in && (state_r == LOCKED) && miss_s;

    // Next-state and next-history/counter logic for the checker FSM.
    always_comb begin
        state_nxt_s = state_r;
        hist_nxt_s  = hist_r;
        fill_nxt_s  = fill_r;
        match_nxt_s = match_r;
        cerr_nxt_s  = cerr_r;
        if (valid_in) begin
            case (state_r)
                HUNT: begin
                    hist_nxt_s = {hist_r[1:0], data_in};
                    if (fill_r == 2'd2) begin
                        // Third bit completes the history window.
                        state_nxt_s = SYNC;
                        fill_nxt_s  = 2'd0;
                        match_nxt_s = 8'd0;
                    end else begin
                        fill_nxt_s = fill_r + 2'd1;
                    end
                end
                SYNC: begin
                    // Reseed from the line so a bad window is flushed out.
                    hist_nxt_s = {hist_r[1:0], data_in};
                    if (miss_s) begin
                        match_nxt_s = 8'd0;
                    end else if ((match_r + 8'd1) == LOCK_CNT_V) begin
                        state_nxt_s = LOCKED;
                        match_nxt_s = 8'd0;
                        cerr_nxt_s  = 4'd0;
                    end else begin
                        match_nxt_s = match_r + 8'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: feed the prediction back so an isolated line
                    // error does not poison later predictions.
                    hist_nxt_s = {hist_r[1:0], pred_s};
                    if (!miss_s) begin
                        cerr_nxt_s = 4'd0;
                    end else if ((cerr_r + 4'd1) == UNLOCK_V) begin
                        state_nxt_s = HUNT;
                        fill_nxt_s  = 2'd0;
                        cerr_nxt_s  = 4'd0;
                    end else begin
                        cerr_nxt_s = cerr_r + 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    hist_nxt_s  = '0;
                    fill_nxt_s  = 2'd0;
                    match_nxt_s = 8'd0;
                    cerr_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state, history and internal counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= HUNT;
            hist_r  <= '0;
            fill_r  <= 2'd0;
            match_r <= 8'd0;
            cerr_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
            match_r <= match_nxt_s;
            cerr_r  <= cerr_nxt_s;
        end
    end

    // Registered status outputs, aligned with the state register update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            state_out_r <= 2'd0;
        end else begin
            locked_r    <= (state_nxt_s == LOCKED);
            err_pulse_r <= lock_err_s;
            state_out_r <= state_nxt_s;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .en    (lock_err_s),
        .count (err_count)
    );

`ifdef LFSR_CHK_BITCNT_EN
    logic lock_bit_s;
    assign lock_bit_s = valid_in && (state_r == LOCKED);

    sat_counter #(.W(32)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .en    (lock_bit_s),
        .count (bit_count)
    );
`endif

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign state_out = state_out_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Two checker instances share one input stream: dut (16-bit error counter)
// and dut_sat (4-bit error counter, to reach saturation). Expected outputs
// come from a reference model that predicts from the known period-8 sequence
// table (each 3-bit window occurs once per period) rather than the feedback
// equation. Optional macro LFSR_CHK_BITCNT_EN also checks bit_count.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        data_in = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_out;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_count;
    logic [1:0]  s_state_out;
`ifdef LFSR_CHK_BITCNT_EN
    logic [31:0] bit_count, s_bit_count;
`endif

    lfsr_checker #(.LOCK_COUNT(8), .UNLOCK_ERRS(3), .ERR_CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef LFSR_CHK_BITCNT_EN
        .bit_count (bit_count),
`endif
        .state_out (state_out)
    );

    lfsr_checker #(.LOCK_COUNT(8), .UNLOCK_ERRS(3), .ERR_CNT_W(4)) dut_sat (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .err_count (s_err_count),
`ifdef LFSR_CHK_BITCNT_EN
        .bit_count (s_bit_count),
`endif
        .state_out (s_state_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    bit seq_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int gph = 0;

    // Reference model state (0=HUNT, 1=SYNC, 2=LOCKED)
    int m_state, m_fill, m_match, m_cerr, m_errs, m_bits;
    bit m_pulse;
    bit m_hist[$];   // [0] oldest .. [2] newest

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Next bit of the period-8 sequence after the current 3-bit window.
    function automatic bit model_pred();
        for (int i = 0; i < 8; i++) begin
            if (seq_tab[i] == m_hist[0] && seq_tab[(i+1)%8] == m_hist[1] &&
                seq_tab[(i+2)%8] == m_hist[2])
                return seq_tab[(i+3)%8];
        end
        return 1'b0;
    endfunction

    task automatic push_hist(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_cerr = 0;
        m_errs = 0; m_bits = 0; m_pulse = 1'b0;
        m_hist = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step(input bit v, input bit d);
        bit p;
        m_pulse = 1'b0;
        if (v) begin
            case (m_state)
                0: begin
                    push_hist(d);
                    m_fill++;
                    if (m_fill == 3) begin m_state = 1; m_match = 0; end
                end
                1: begin
                    p = model_pred();
                    if (d == p) begin
                        m_match++;
                        if (m_match == 8) begin m_state = 2; m_cerr = 0; end
                    end else begin
                        m_match = 0;
                    end
                    push_hist(d);
                end
                default: begin
                    p = model_pred();
                    m_bits++;
                    if (d != p) begin m_pulse = 1'b1; m_errs++; m_cerr++; end
                    else m_cerr = 0;
                    push_hist(p);
                    if (m_cerr == 3) begin m_state = 0; m_fill = 0; end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked",      locked,      32'(m_state == 2));
        chk("err_pulse",   err_pulse,   32'(m_pulse));
        chk("err_count",   err_count,   32'(sat(m_errs, 65535)));
        chk("state_out",   state_out,   32'(m_state));
        chk("s_locked",    s_locked,    32'(m_state == 2));
        chk("s_err_pulse", s_err_pulse, 32'(m_pulse));
        chk("s_err_count", s_err_count, 32'(sat(m_errs, 15)));
        chk("s_state_out", s_state_out, 32'(m_state));
`ifdef LFSR_CHK_BITCNT_EN
        chk("bit_count",   bit_count,   32'(m_bits));
        chk("s_bit_count", s_bit_count, 32'(m_bits));
`endif
    endtask

    task automatic cycle(input bit v, input bit d);
        valid_in = v;
        data_in  = d;
        @(posedge clock);
        model_step(v, d);
        #1;
        check_all();
    endtask

    task automatic send_gen(input int n, input bit inv);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = seq_tab[gph];
            gph = (gph + 1) % 8;
            cycle(1'b1, b ^ inv);
        end
    endtask

    // Assert reset away from the clock edge and check outputs clear at once.
    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        gph = $urandom_range(0, 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b, e, v;
        int pulses;
        logic [1:0] prev;

        // Reset state
        do_reset();
        chk("reset_locked", locked, 32'd0);
        chk("reset_state", state_out, 32'd0);

        // Clean lock
        send_gen(2, 1'b0);
        chk("hunt_after_2", state_out, 32'd0);
        send_gen(1, 1'b0);
        chk("sync_after_3", state_out, 32'd1);
        send_gen(7, 1'b0);
        chk("not_locked_after_7", locked, 32'd0);
        send_gen(1, 1'b0);
        chk("locked_after_8", locked, 32'd1);
        chk("clean_err_count", err_count, 32'd0);

        // Single error while locked, then flywheel keeps predictions right
        b = seq_tab[gph]; gph = (gph + 1) % 8;
        cycle(1'b1, ~b);
        chk("single_pulse", err_pulse, 32'd1);
        chk("single_count", err_count, 32'd1);
        chk("single_still_locked", locked, 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send_gen(1, 1'b0);
            if (err_pulse === 1'b1) pulses++;
        end
        chk("flywheel_quiet", pulses, 32'd0);
        chk("flywheel_count", err_count, 32'd1);

        // Unlock by three consecutive errors, then relock
        do_reset();
        send_gen(11, 1'b0);
        chk("unlock_pre_locked", locked, 32'd1);
        send_gen(2, 1'b1);
        chk("unlock_two_errs_locked", locked, 32'd1);
        send_gen(1, 1'b1);
        chk("unlock_pulse", err_pulse, 32'd1);
        chk("unlock_locked", locked, 32'd0);
        chk("unlock_state", state_out, 32'd0);
        chk("unlock_count", err_count, 32'd3);
        send_gen(3, 1'b0);
        chk("relock_sync", state_out, 32'd1);
        send_gen(7, 1'b0);
        chk("relock_not_yet", locked, 32'd0);
        send_gen(1, 1'b0);
        chk("relock_locked", locked, 32'd1);
        chk("relock_count_held", err_count, 32'd3);

        // Sync reseed: wrong bit after 5 matches
        do_reset();
        send_gen(8, 1'b0);
        chk("reseed_in_sync", state_out, 32'd1);
        b = seq_tab[gph]; gph = (gph + 1) % 8;
        cycle(1'b1, ~b);
        chk("reseed_no_pulse", err_pulse, 32'd0);
        chk("reseed_state", state_out, 32'd1);
        send_gen(7, 1'b0);
        chk("reseed_not_locked", locked, 32'd0);
        for (int i = 0; i < 40 && locked !== 1'b1; i++) send_gen(1, 1'b0);
        chk("reseed_relock", locked, 32'd1);
        chk("reseed_err_count", err_count, 32'd0);

        // Random gaps and sparse errors during lock
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                b = seq_tab[gph]; gph = (gph + 1) % 8;
                e = ($urandom_range(0, 11) == 0);
                cycle(1'b1, b ^ e);
            end else begin
                prev = state_out;
                cycle(1'b0, 1'($urandom_range(0, 1)));
                chk("gap_hold", state_out, prev);
                chk("gap_no_pulse", err_pulse, 32'd0);
            end
        end

        // Mid-stream reset (do_reset checks outputs before the next edge)
        send_gen(5, 1'b1);
        do_reset();
        chk("midreset_count", err_count, 32'd0);

        // Saturation: repeated lock / three inverted bits
        send_gen(11, 1'b0);
        for (int r = 0; r < 8; r++) begin
            send_gen(3, 1'b1);
            send_gen(11, 1'b0);
        end
        chk("sat_narrow", s_err_count, 32'd15);
        chk("sat_wide", err_count, 32'd24);
`ifdef LFSR_CHK_BITCNT_EN
        chk("bitcnt_locked_only", bit_count, 32'd24);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
